// File: rtl/time_disp_pkg.sv
// Shared definitions for the time display scanner: time-word field layout,
// field limits, segment constants and the conversion FSM state type.
package time_disp_pkg;

  localparam int TIME_W  = 27;
  localparam int HR_MSB  = 26;
  localparam int HR_LSB  = 22;
  localparam int MIN_MSB = 21;
  localparam int MIN_LSB = 16;
  localparam int SEC_MSB = 15;
  localparam int SEC_LSB = 10;
  localparam int MS_MSB  = 9;
  localparam int MS_LSB  = 0;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [9:0] MS_MAX  = 10'd999;

  // Segment words are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAP,
    ST_SHIFT,
    ST_DONE
  } conv_state_e;

  // dig[7] is the leftmost digit (hours tens); dots_on already folds in BLINK_EN.
  typedef struct packed {
    logic [7:0][3:0] dig;
    logic            valid;
    logic            dots_on;
  } disp_bank_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/time_disp_scan_bin2bcd.sv
// Sequential 10-bit binary to 3-digit BCD converter (shift-add-3).
// A start pulse loads the operand; done is high during the last of 10 shifts.
module bin2bcd_seq (
  input  logic        kh_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  // sh = {hundreds, tens, ones, remaining binary bits}
  logic [21:0] sh;
  logic [21:0] adj;
  logic [3:0]  cnt;

  always_comb begin
    adj = sh;
    for (int i = 0; i < 3; i++) begin
      if (sh[10+4*i +: 4] >= 4'd5) adj[10+4*i +: 4] = sh[10+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (start) begin
      sh  <= {12'd0, bin};
      cnt <= 4'd10;
    end else if (cnt != 4'd0) begin
      sh  <= {adj[20:0], 1'b0};
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd1);
  assign bcd  = sh[21:10];

endmodule

// File: rtl/time_disp_scan.sv
// 8-digit multiplexed 7-seg driver showing HH.MM.SS.cc from a packed time word,
// with a once-per-frame coherent snapshot, range check and BCD conversion.
module time_disp_scan
  import time_disp_pkg::*;
#(
  parameter int DIGIT_HOLD = 2,
  parameter bit BLINK_EN   = 1'b1
) (
  input  logic              kh_clk,
  input  logic              reset_n,
  input  logic [TIME_W-1:0] disp_time,
  output logic [7:0]        an_n,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic              err
);

  localparam int HW = $clog2(DIGIT_HOLD);

  logic [HW-1:0] hold_cnt;
  logic [2:0]    dig_idx;
  logic          frame_start;

  assign frame_start = (dig_idx == 3'd7) && (hold_cnt == '0);

  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      dig_idx  <= 3'd7;
    end else if (hold_cnt == HW'(DIGIT_HOLD - 1)) begin
      hold_cnt <= '0;
      dig_idx  <= dig_idx - 3'd1;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Conversion sequencer
  conv_state_e state, state_nxt;
  logic        cap_en, conv_start, pend_load, conv_done;

  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cap_en     = 1'b0;
    conv_start = 1'b0;
    pend_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          cap_en    = 1'b1;
          state_nxt = ST_CAP;
        end
      end
      ST_CAP: begin
        conv_start = 1'b1;
        state_nxt  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (conv_done) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        pend_load = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic [TIME_W-1:0] snap;
  logic              snap_valid;

  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      snap       <= '0;
      snap_valid <= 1'b0;
    end else if (cap_en) begin
      snap       <= disp_time;
      snap_valid <= (disp_time[HR_MSB:HR_LSB]   <= HR_MAX)  &&
                    (disp_time[MIN_MSB:MIN_LSB] <= MIN_MAX) &&
                    (disp_time[SEC_MSB:SEC_LSB] <= SEC_MAX) &&
                    (disp_time[MS_MSB:MS_LSB]   <= MS_MAX);
    end
  end

  logic [11:0] hr_bcd, min_bcd, sec_bcd, ms_bcd;
  logic        hr_done, min_done, sec_done, ms_done;

  bin2bcd_seq u_hr (
    .kh_clk(kh_clk), .reset_n(reset_n), .start(conv_start),
    .bin({5'd0, snap[HR_MSB:HR_LSB]}), .done(hr_done), .bcd(hr_bcd)
  );
  bin2bcd_seq u_min (
    .kh_clk(kh_clk), .reset_n(reset_n), .start(conv_start),
    .bin({4'd0, snap[MIN_MSB:MIN_LSB]}), .done(min_done), .bcd(min_bcd)
  );
  bin2bcd_seq u_sec (
    .kh_clk(kh_clk), .reset_n(reset_n), .start(conv_start),
    .bin({4'd0, snap[SEC_MSB:SEC_LSB]}), .done(sec_done), .bcd(sec_bcd)
  );
  bin2bcd_seq u_ms (
    .kh_clk(kh_clk), .reset_n(reset_n), .start(conv_start),
    .bin(snap[MS_MSB:MS_LSB]), .done(ms_done), .bcd(ms_bcd)
  );

  assign conv_done = hr_done & min_done & sec_done & ms_done;

  // Hundreds of hr/min/sec are always zero for in-range values; ms ones is not displayed.
  logic unused_bcd_bits;
  assign unused_bcd_bits = ^{hr_bcd[11:8], min_bcd[11:8], sec_bcd[11:8], ms_bcd[3:0]};

  disp_bank_t pend, bank, bank_nxt;
  logic       pend_ready, bank_valid, bank_valid_nxt;

  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend       <= '0;
      pend_ready <= 1'b0;
    end else if (pend_load) begin
      pend.dig     <= {hr_bcd[7:4], hr_bcd[3:0], min_bcd[7:4], min_bcd[3:0],
                       sec_bcd[7:4], sec_bcd[3:0], ms_bcd[11:8], ms_bcd[7:4]};
      pend.valid   <= snap_valid;
      pend.dots_on <= !BLINK_EN || (snap[MS_MSB:MS_LSB] < 10'd500);
      pend_ready   <= 1'b1;
    end
  end

  always_comb begin
    bank_nxt       = bank;
    bank_valid_nxt = bank_valid;
    if (frame_start && pend_ready) begin
      bank_nxt       = pend;
      bank_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      bank       <= '0;
      bank_valid <= 1'b0;
    end else begin
      bank       <= bank_nxt;
      bank_valid <= bank_valid_nxt;
    end
  end

  // Output mux reads the bank as it will be after this edge, so a newly
  // loaded frame appears on digit 7 in the same cycle the frame starts.
  logic [7:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d, err_d;
  logic       dot_pos;

  always_comb begin
    an_d    = 8'hFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    err_d   = 1'b0;
    dot_pos = (dig_idx == 3'd6) || (dig_idx == 3'd4) || (dig_idx == 3'd2);
    if (bank_valid_nxt) begin
      an_d = ~(8'b1 << dig_idx);
      if (bank_nxt.valid) begin
        seg_d = bcd_to_seg(bank_nxt.dig[dig_idx]);
        dp_d  = !(bank_nxt.dots_on && dot_pos);
      end else begin
        seg_d = SEG_DASH;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      an_n  <= 8'hFF;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
      err   <= 1'b0;
    end else begin
      an_n  <= an_d;
      seg_n <= seg_d;
      dp_n  <= dp_d;
      err   <= err_d;
    end
  end

endmodule
